// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - RV32IM fetch stage with busywait imem port, stall hold buffer and redirect drain
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps into a FAULT state).
module instruction_fetch_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IMEM_ADDRESS,
    output logic        IMEM_READ,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS_4,
    output logic        INSTR_VALID,
    output logic        FETCH_BUSY,
    output logic        MISALIGN_FAULT
);

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        ,ST_FAULT = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        fault_pend_q, fault_pend_d;
    logic [31:0] target;
    logic        misaligned;
    logic        accept;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target     = BRANCH_TARGET;
    assign misaligned = |BRANCH_TARGET[1:0];
`else
    assign target     = {BRANCH_TARGET[31:2], 2'b00};
    assign misaligned = 1'b0;
`endif

    assign accept = (state_q == ST_REQ) && !IMEM_BUSYWAIT;

    always_comb begin
        state_d      = state_q;
        pc_next_d    = pc_next_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_addr_d  = hold_addr_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        fault_pend_d = fault_pend_q;
        if (BRANCH_TAKEN) begin
            instr_d      = NOP_INSTR;
            valid_d      = 1'b0;
            pc_next_d    = target;
            fault_pend_d = misaligned;
            // An outstanding request must complete before the target can be issued.
            if ((state_q == ST_REQ || state_q == ST_DRAIN) && IMEM_BUSYWAIT) begin
                state_d = ST_DRAIN;
            end else if (misaligned) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                state_d = ST_FAULT;
`endif
            end else begin
                req_addr_d = target;
                state_d    = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (accept && STALL) begin
                        hold_instr_d = IMEM_READDATA;
                        hold_addr_d  = req_addr_q;
                        state_d      = ST_HOLD;
                    end else if (accept) begin
                        instr_d    = IMEM_READDATA;
                        pc_d       = req_addr_q;
                        pc4_d      = req_addr_q + 32'd4;
                        valid_d    = 1'b1;
                        pc_next_d  = req_addr_q + 32'd4;
                        req_addr_d = req_addr_q + 32'd4;
                    end
                end
                ST_HOLD: begin
                    if (!STALL) begin
                        instr_d    = hold_instr_q;
                        pc_d       = hold_addr_q;
                        pc4_d      = hold_addr_q + 32'd4;
                        valid_d    = 1'b1;
                        pc_next_d  = hold_addr_q + 32'd4;
                        req_addr_d = hold_addr_q + 32'd4;
                        state_d    = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (!IMEM_BUSYWAIT) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (fault_pend_q) begin
                            state_d = ST_FAULT;
                        end else begin
                            req_addr_d = pc_next_q;
                            state_d    = ST_REQ;
                        end
`else
                        req_addr_d = pc_next_q;
                        state_d    = ST_REQ;
`endif
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_REQ;
            pc_next_q    <= RESET_VECTOR;
            req_addr_q   <= RESET_VECTOR;
            hold_instr_q <= NOP_INSTR;
            hold_addr_q  <= 32'd0;
            instr_q      <= NOP_INSTR;
            pc_q         <= 32'd0;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
            fault_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_next_q    <= pc_next_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_addr_q  <= hold_addr_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            fault_pend_q <= fault_pend_d;
        end
    end

    assign IMEM_ADDRESS = req_addr_q;
    assign IMEM_READ    = !RESET && (state_q == ST_REQ || state_q == ST_DRAIN);
    assign INSTRUCTION  = instr_q;
    assign PC           = pc_q;
    assign PC_PLUS_4    = pc4_q;
    assign INSTR_VALID  = valid_q;
    assign FETCH_BUSY   = (state_q == ST_REQ && IMEM_BUSYWAIT) || (state_q == ST_DRAIN);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign MISALIGN_FAULT = (state_q == ST_FAULT);
`else
    assign MISALIGN_FAULT = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET, STALL, BRANCH_TAKEN, IMEM_BUSYWAIT;
    logic [31:0] BRANCH_TARGET, IMEM_READDATA, IMEM_ADDRESS;
    logic        IMEM_READ, INSTR_VALID, FETCH_BUSY, MISALIGN_FAULT;
    logic [31:0] INSTRUCTION, PC, PC_PLUS_4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    // memory returns word == address
    assign IMEM_READDATA = IMEM_ADDRESS;

    instruction_fetch_unit dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET), .IMEM_READDATA(IMEM_READDATA),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IMEM_ADDRESS(IMEM_ADDRESS), .IMEM_READ(IMEM_READ),
        .INSTRUCTION(INSTRUCTION), .PC(PC), .PC_PLUS_4(PC_PLUS_4), .INSTR_VALID(INSTR_VALID),
        .FETCH_BUSY(FETCH_BUSY), .MISALIGN_FAULT(MISALIGN_FAULT)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'd0; IMEM_BUSYWAIT = 1'b0;
        step(); step();
        n_cmp++; if (IMEM_READ !== 1'b0) begin n_bad++; $display("FAIL rst_read got %b want 0", IMEM_READ); end
        n_cmp++; if (INSTRUCTION !== NOP) begin n_bad++; $display("FAIL rst_instr got %h want %h", INSTRUCTION, NOP); end
        n_cmp++; if (PC !== 32'd0) begin n_bad++; $display("FAIL rst_pc got %h want 0", PC); end
        n_cmp++; if (PC_PLUS_4 !== 32'd0) begin n_bad++; $display("FAIL rst_pc4 got %h want 0", PC_PLUS_4); end
        n_cmp++; if (INSTR_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", INSTR_VALID); end
        n_cmp++; if (MISALIGN_FAULT !== 1'b0) begin n_bad++; $display("FAIL rst_fault got %b want 0", MISALIGN_FAULT); end
        RESET = 1'b0;
        #1;
        n_cmp++; if (IMEM_READ !== 1'b1 || IMEM_ADDRESS !== 32'd0) begin n_bad++; $display("FAIL first_req got %b/%h want 1/0", IMEM_READ, IMEM_ADDRESS); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (PC !== 32'(i*4) || INSTRUCTION !== 32'(i*4) || PC_PLUS_4 !== 32'(i*4+4) || INSTR_VALID !== 1'b1) begin
                n_bad++; $display("FAIL stream%0d got pc=%h ins=%h pc4=%h v=%b want pc=%h", i, PC, INSTRUCTION, PC_PLUS_4, INSTR_VALID, i*4);
            end
        end
    endtask

    task automatic test_busywait();
        IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (FETCH_BUSY !== 1'b1 || IMEM_ADDRESS !== 32'h8 || PC !== 32'h4) begin
                n_bad++; $display("FAIL busy%0d got busy=%b addr=%h pc=%h want 1/8/4", i, FETCH_BUSY, IMEM_ADDRESS, PC);
            end
            step();
        end
        IMEM_BUSYWAIT = 1'b0;
        #1;
        n_cmp++; if (FETCH_BUSY !== 1'b0) begin n_bad++; $display("FAIL busy_drop got %b want 0", FETCH_BUSY); end
        step();
        n_cmp++; if (PC !== 32'h8 || INSTRUCTION !== 32'h8) begin n_bad++; $display("FAIL busy_done got pc=%h ins=%h want 8", PC, INSTRUCTION); end
    endtask

    task automatic test_stall();
        step();
        n_cmp++; if (PC !== 32'hC) begin n_bad++; $display("FAIL pre_stall got pc=%h want c", PC); end
        STALL = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (PC !== 32'hC || IMEM_READ !== 1'b0 || INSTRUCTION !== 32'hC) begin
                n_bad++; $display("FAIL hold%0d got pc=%h rd=%b want pc=c rd=0", i, PC, IMEM_READ);
            end
        end
        STALL = 1'b0;
        step();
        n_cmp++; if (PC !== 32'h10 || INSTRUCTION !== 32'h10 || PC_PLUS_4 !== 32'h14 || IMEM_ADDRESS !== 32'h14 || IMEM_READ !== 1'b1) begin
            n_bad++; $display("FAIL unhold got pc=%h ins=%h addr=%h rd=%b want 10/10/14/1", PC, INSTRUCTION, IMEM_ADDRESS, IMEM_READ);
        end
        step();
        n_cmp++; if (PC !== 32'h14) begin n_bad++; $display("FAIL post_hold got pc=%h want 14", PC); end
    endtask

    task automatic test_branch_drain();
        step(); step();
        n_cmp++; if (PC !== 32'h1C || IMEM_ADDRESS !== 32'h20) begin n_bad++; $display("FAIL pre_br got pc=%h addr=%h want 1c/20", PC, IMEM_ADDRESS); end
        IMEM_BUSYWAIT = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h100;
        step();
        BRANCH_TAKEN = 1'b0;
        n_cmp++; if (INSTRUCTION !== NOP || INSTR_VALID !== 1'b0 || FETCH_BUSY !== 1'b1 || IMEM_READ !== 1'b1 || IMEM_ADDRESS !== 32'h20) begin
            n_bad++; $display("FAIL drain got ins=%h v=%b busy=%b rd=%b addr=%h want nop/0/1/1/20", INSTRUCTION, INSTR_VALID, FETCH_BUSY, IMEM_READ, IMEM_ADDRESS);
        end
        step();
        n_cmp++; if (FETCH_BUSY !== 1'b1 || IMEM_ADDRESS !== 32'h20) begin n_bad++; $display("FAIL drain2 got busy=%b addr=%h want 1/20", FETCH_BUSY, IMEM_ADDRESS); end
        IMEM_BUSYWAIT = 1'b0;
        step();
        n_cmp++; if (IMEM_ADDRESS !== 32'h100 || INSTRUCTION !== NOP || INSTR_VALID !== 1'b0 || FETCH_BUSY !== 1'b0) begin
            n_bad++; $display("FAIL drain_done got addr=%h ins=%h v=%b busy=%b want 100/nop/0/0", IMEM_ADDRESS, INSTRUCTION, INSTR_VALID, FETCH_BUSY);
        end
        step();
        n_cmp++; if (PC !== 32'h100 || INSTRUCTION !== 32'h100 || INSTR_VALID !== 1'b1) begin n_bad++; $display("FAIL br_target got pc=%h ins=%h want 100", PC, INSTRUCTION); end
    endtask

    task automatic test_back_to_back();
        STALL = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h200;
        step();
        STALL = 1'b0; BRANCH_TAKEN = 1'b0;
        n_cmp++; if (INSTR_VALID !== 1'b0 || INSTRUCTION !== NOP || IMEM_ADDRESS !== 32'h200 || IMEM_READ !== 1'b1) begin
            n_bad++; $display("FAIL br_stall got v=%b ins=%h addr=%h rd=%b want 0/nop/200/1", INSTR_VALID, INSTRUCTION, IMEM_ADDRESS, IMEM_READ);
        end
        step();
        n_cmp++; if (PC !== 32'h200 || INSTR_VALID !== 1'b1) begin n_bad++; $display("FAIL br_stall_tgt got pc=%h v=%b want 200/1", PC, INSTR_VALID); end
        IMEM_BUSYWAIT = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h300;
        step();
        BRANCH_TAKEN = 1'b0;
        n_cmp++; if (FETCH_BUSY !== 1'b1 || IMEM_ADDRESS !== 32'h204) begin n_bad++; $display("FAIL drain_b got busy=%b addr=%h want 1/204", FETCH_BUSY, IMEM_ADDRESS); end
        RESET = 1'b1;
        #1;
        n_cmp++; if (INSTRUCTION !== NOP || PC !== 32'd0 || PC_PLUS_4 !== 32'd0 || INSTR_VALID !== 1'b0 || IMEM_READ !== 1'b0 || IMEM_ADDRESS !== 32'd0) begin
            n_bad++; $display("FAIL mid_rst got ins=%h pc=%h pc4=%h v=%b rd=%b addr=%h want reset values", INSTRUCTION, PC, PC_PLUS_4, INSTR_VALID, IMEM_READ, IMEM_ADDRESS);
        end
        IMEM_BUSYWAIT = 1'b0;
        step();
        RESET = 1'b0;
        #1;
        n_cmp++; if (IMEM_READ !== 1'b1 || IMEM_ADDRESS !== 32'd0) begin n_bad++; $display("FAIL rst_req got rd=%b addr=%h want 1/0", IMEM_READ, IMEM_ADDRESS); end
        step();
        n_cmp++; if (PC !== 32'd0 || INSTRUCTION !== 32'd0 || INSTR_VALID !== 1'b1) begin n_bad++; $display("FAIL rst_fetch got pc=%h v=%b want 0/1", PC, INSTR_VALID); end
    endtask

    task automatic test_misalign();
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h102;
        step();
        BRANCH_TAKEN = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (MISALIGN_FAULT !== 1'b1 || IMEM_READ !== 1'b0 || INSTR_VALID !== 1'b0) begin
                n_bad++; $display("FAIL fault%0d got mf=%b rd=%b v=%b want 1/0/0", i, MISALIGN_FAULT, IMEM_READ, INSTR_VALID);
            end
            step();
        end
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h200;
        step();
        BRANCH_TAKEN = 1'b0;
        n_cmp++; if (MISALIGN_FAULT !== 1'b0 || IMEM_READ !== 1'b1 || IMEM_ADDRESS !== 32'h200) begin
            n_bad++; $display("FAIL fault_exit got mf=%b rd=%b addr=%h want 0/1/200", MISALIGN_FAULT, IMEM_READ, IMEM_ADDRESS);
        end
        step();
        n_cmp++; if (PC !== 32'h200 || INSTR_VALID !== 1'b1) begin n_bad++; $display("FAIL fault_resume got pc=%h want 200", PC); end
`else
        n_cmp++; if (MISALIGN_FAULT !== 1'b0 || IMEM_READ !== 1'b1 || IMEM_ADDRESS !== 32'h100) begin
            n_bad++; $display("FAIL align got mf=%b rd=%b addr=%h want 0/1/100", MISALIGN_FAULT, IMEM_READ, IMEM_ADDRESS);
        end
        step();
        n_cmp++; if (PC !== 32'h100 || INSTRUCTION !== 32'h100) begin n_bad++; $display("FAIL align_fetch got pc=%h want 100", PC); end
`endif
    endtask

    task automatic test_wrap();
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
        step();
        BRANCH_TAKEN = 1'b0;
        step();
        n_cmp++; if (PC !== 32'hFFFF_FFFC || PC_PLUS_4 !== 32'd0 || IMEM_ADDRESS !== 32'd0) begin
            n_bad++; $display("FAIL wrap got pc=%h pc4=%h addr=%h want fffffffc/0/0", PC, PC_PLUS_4, IMEM_ADDRESS);
        end
        step();
        n_cmp++; if (PC !== 32'd0 || PC_PLUS_4 !== 32'h4) begin n_bad++; $display("FAIL wrap2 got pc=%h pc4=%h want 0/4", PC, PC_PLUS_4); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_busywait();
        test_stall();
        test_branch_drain();
        test_back_to_back();
        test_misalign();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
